// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared load/store size encodings and load-tracker entry layout
package arm_mem_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef struct packed {
      logic [1:0]        size;
      logic              sgn;
      logic [1:0]        addr_lo;
      logic              err;
      logic              done;
      logic [DATA_W-1:0] data;
   } load_entry_t;

   localparam int LOAD_ENTRY_W = $bits(load_entry_t);

endpackage

// File: rtl/mem_load_align_if.sv
// rtl/mem_load_align_if.sv - request, memory response and writeback signals of the load aligner
interface mem_load_align_if;

   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_addr_lo;
   logic [1:0]  req_size;
   logic        req_signed;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic        wb_err;

   modport slave (
      input  req_valid, req_addr_lo, req_size, req_signed, mem_rvalid, mem_rdata, wb_ready,
      output req_ready, wb_valid, wb_data, wb_err
   );

   modport master (
      output req_valid, req_addr_lo, req_size, req_signed, mem_rvalid, mem_rdata, wb_ready,
      input  req_ready, wb_valid, wb_data, wb_err
   );

endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - little-endian lane extract, sign/zero extend and alignment check
module load_extend
   import arm_mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] data_o,
   output logic        err_o
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
      lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      err_o  = 1'b0;
      data_o = '0;
      case (size_i)
         SZ_BYTE: data_o = {{24{signed_i & lane_b[7]}}, lane_b};
         SZ_HALF: begin
            err_o  = addr_lo_i[0];
            data_o = {{16{signed_i & lane_h[15]}}, lane_h};
         end
         SZ_WORD: begin
            err_o  = (addr_lo_i != 2'b00);
            data_o = rdata_i;
         end
         default: err_o = 1'b1;
      endcase
      if (err_o) data_o = '0;
   end

endmodule

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - in-order load tracker pairing memory responses with requests
module mem_load_align
   import arm_mem_pkg::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int DW          = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   mem_load_align_if.slave  bus,
   output logic             proto_err
);

   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = $clog2(OUTSTANDING + 1);

   load_entry_t     ent_q [OUTSTANDING];
   logic [PW-1:0]   alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
   logic [CW-1:0]   count_q, count_d, unfilled_q, unfilled_d;
   logic            proto_q, proto_d;
   logic            accept, fill, pop, stray;
   logic [DW-1:0]   ext_data;
   logic            ext_err;

   load_extend u_extend (
      .rdata_i   (bus.mem_rdata),
      .addr_lo_i (ent_q[fill_q].addr_lo),
      .size_i    (ent_q[fill_q].size),
      .signed_i  (ent_q[fill_q].sgn),
      .data_o    (ext_data),
      .err_o     (ext_err)
   );

   // Registered count only, so a same-cycle pop never feeds back into req_ready.
   assign bus.req_ready = (count_q != CW'(OUTSTANDING));
   assign bus.wb_valid  = ent_q[head_q].done;
   assign bus.wb_data   = bus.wb_valid ? ent_q[head_q].data : '0;
   assign bus.wb_err    = bus.wb_valid & ent_q[head_q].err;
   assign proto_err     = proto_q;

   always_comb begin
      accept     = bus.req_valid & bus.req_ready;
      fill       = bus.mem_rvalid & (unfilled_q != '0);
      stray      = bus.mem_rvalid & (unfilled_q == '0);
      pop        = bus.wb_valid & bus.wb_ready;
      alloc_d    = accept ? alloc_q + PW'(1) : alloc_q;
      fill_d     = fill   ? fill_q  + PW'(1) : fill_q;
      head_d     = pop    ? head_q  + PW'(1) : head_q;
      count_d    = count_q + CW'(accept) - CW'(pop);
      unfilled_d = unfilled_q + CW'(accept) - CW'(fill);
      proto_d    = proto_q | stray;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alloc_q    <= '0;
         fill_q     <= '0;
         head_q     <= '0;
         count_q    <= '0;
         unfilled_q <= '0;
         proto_q    <= 1'b0;
         for (int i = 0; i < OUTSTANDING; i++) ent_q[i] <= '0;
      end else begin
         alloc_q    <= alloc_d;
         fill_q     <= fill_d;
         head_q     <= head_d;
         count_q    <= count_d;
         unfilled_q <= unfilled_d;
         proto_q    <= proto_d;
         // Accept, fill and pop always address different entries, so their order here is free.
         if (pop) ent_q[head_q].done <= 1'b0;
         if (fill) begin
            ent_q[fill_q].data <= ext_data;
            ent_q[fill_q].err  <= ext_err;
            ent_q[fill_q].done <= 1'b1;
         end
         if (accept) begin
            ent_q[alloc_q].size    <= bus.req_size;
            ent_q[alloc_q].sgn     <= bus.req_signed;
            ent_q[alloc_q].addr_lo <= bus.req_addr_lo;
            ent_q[alloc_q].err     <= 1'b0;
            ent_q[alloc_q].done    <= 1'b0;
            ent_q[alloc_q].data    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_load_align.sv
// tb/tb_mem_load_align.sv - self-checking bench for mem_load_align
module tb_mem_load_align;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic proto_err;
   int   checks = 0;
   int   errors = 0;

   mem_load_align_if bus ();

   mem_load_align #(.OUTSTANDING(2), .DW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  size;
      logic [1:0]  a;
      logic        s;
      logic [31:0] rd;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   typedef struct {
      logic [1:0] size;
      logic [1:0] a;
      logic       s;
   } req_t;

   vec_t        vecs [11];
   req_t        pend [$];
   logic [32:0] results [$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [32:0] ref_load(input logic [1:0] sz, input logic [1:0] a,
                                            input logic s, input logic [31:0] rd);
      int unsigned v;
      int unsigned ai;
      ai = int'(a);
      if (sz == 2'd3 || (sz == 2'd1 && ai % 2 == 1) || (sz == 2'd2 && ai != 0))
         return {1'b1, 32'h0};
      if (sz == 2'd0) begin
         v = (rd >> (8 * ai)) % 256;
         if (s && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (rd >> (16 * (ai / 2))) % 65536;
         if (s && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return {1'b0, v};
   endfunction

   task automatic set_req(input logic v, input logic [1:0] sz, input logic [1:0] a, input logic s);
      bus.req_valid   = v;
      bus.req_size    = sz;
      bus.req_addr_lo = a;
      bus.req_signed  = s;
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic run_model(input int cycles, input bit full_rate);
      logic        rv, wr, fv, exp_ready;
      logic [31:0] rd;
      req_t        r;
      for (int c = 0; c < cycles; c++) begin
         exp_ready = (pend.size() + results.size()) != 2;
         chk("rnd_req_ready", 32'(bus.req_ready), 32'(exp_ready));
         chk("rnd_wb_valid", 32'(bus.wb_valid), 32'(results.size() != 0));
         if (results.size() != 0) begin
            chk("rnd_wb_data", bus.wb_data, results[0][31:0]);
            chk("rnd_wb_err", 32'(bus.wb_err), 32'(results[0][32]));
         end
         chk("rnd_proto", 32'(proto_err), 32'h0);
         rv     = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
         wr     = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
         fv     = (pend.size() != 0) && (full_rate || $urandom_range(0, 2) != 0);
         r.size = 2'($urandom_range(0, 3));
         r.a    = 2'($urandom_range(0, 3));
         r.s    = 1'($urandom_range(0, 1));
         rd     = $urandom;
         set_req(rv, r.size, r.a, r.s);
         bus.mem_rvalid = fv;
         bus.mem_rdata  = rd;
         bus.wb_ready   = wr;
         step();
         if (wr && results.size() != 0) void'(results.pop_front());
         if (fv) begin
            req_t p;
            p = pend.pop_front();
            results.push_back(ref_load(p.size, p.a, p.s, rd));
         end
         if (rv && exp_ready) pend.push_back(r);
      end
      set_req(1'b0, 2'd0, 2'd0, 1'b0);
      bus.mem_rvalid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{2'd0, 2'd3, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0};
      vecs[1]  = '{2'd1, 2'd2, 1'b0, 32'h8001_5555, 32'h0000_8001, 1'b0};
      vecs[2]  = '{2'd1, 2'd0, 1'b0, 32'h8001_5555, 32'h0000_5555, 1'b0};
      vecs[3]  = '{2'd1, 2'd1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
      vecs[4]  = '{2'd2, 2'd0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vecs[5]  = '{2'd0, 2'd1, 1'b0, 32'h80FF_1234, 32'h0000_0012, 1'b0};
      vecs[6]  = '{2'd0, 2'd2, 1'b1, 32'h80FF_1234, 32'hFFFF_FFFF, 1'b0};
      vecs[7]  = '{2'd1, 2'd2, 1'b1, 32'h8001_5555, 32'hFFFF_8001, 1'b0};
      vecs[8]  = '{2'd3, 2'd0, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b1};
      vecs[9]  = '{2'd2, 2'd2, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b1};
      vecs[10] = '{2'd2, 2'd0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0};

      set_req(1'b0, 2'd0, 2'd0, 1'b0);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      bus.wb_ready   = 1'b0;
      step();
      step();
      chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
      chk("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
      chk("rst_wb_data", bus.wb_data, 32'h0);
      chk("rst_wb_err", 32'(bus.wb_err), 32'h0);
      chk("rst_proto", 32'(proto_err), 32'h0);
      rst_n = 1'b1;
      step();

      bus.wb_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         set_req(1'b1, vecs[i].size, vecs[i].a, vecs[i].s);
         step();
         set_req(1'b0, 2'd0, 2'd0, 1'b0);
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = vecs[i].rd;
         chk($sformatf("vec%0d_prefill_valid", i), 32'(bus.wb_valid), 32'h0);
         step();
         bus.mem_rvalid = 1'b0;
         chk($sformatf("vec%0d_valid", i), 32'(bus.wb_valid), 32'h1);
         chk($sformatf("vec%0d_data", i), bus.wb_data, vecs[i].exp_d);
         chk($sformatf("vec%0d_err", i), 32'(bus.wb_err), 32'(vecs[i].exp_e));
         step();
      end
      chk("vec_proto", 32'(proto_err), 32'h0);

      bus.wb_ready = 1'b0;
      set_req(1'b1, 2'd2, 2'd0, 1'b0);
      step();
      step();
      set_req(1'b0, 2'd0, 2'd0, 1'b0);
      chk("full_req_ready", 32'(bus.req_ready), 32'h0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1111_1111;
      step();
      bus.mem_rdata  = 32'h2222_2222;
      step();
      bus.mem_rvalid = 1'b0;
      chk("bp_valid", 32'(bus.wb_valid), 32'h1);
      chk("bp_data0", bus.wb_data, 32'h1111_1111);
      step();
      chk("bp_data_stable", bus.wb_data, 32'h1111_1111);
      bus.wb_ready = 1'b1;
      chk("bp_ready_no_comb", 32'(bus.req_ready), 32'h0);
      step();
      chk("bp_ready_after_pop", 32'(bus.req_ready), 32'h1);
      chk("bp_data1", bus.wb_data, 32'h2222_2222);
      step();
      chk("bp_drained", 32'(bus.wb_valid), 32'h0);

      bus.mem_rvalid = 1'b1;
      step();
      bus.mem_rvalid = 1'b0;
      chk("proto_set", 32'(proto_err), 32'h1);
      step();
      chk("proto_sticky", 32'(proto_err), 32'h1);

      bus.wb_ready = 1'b0;
      set_req(1'b1, 2'd0, 2'd0, 1'b0);
      step();
      step();
      set_req(1'b0, 2'd0, 2'd0, 1'b0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hA5A5_A5A5;
      step();
      bus.mem_rvalid = 1'b0;
      chk("mid_valid_before_rst", 32'(bus.wb_valid), 32'h1);
      do_reset();
      chk("mid_rst_wb_valid", 32'(bus.wb_valid), 32'h0);
      chk("mid_rst_req_ready", 32'(bus.req_ready), 32'h1);
      chk("mid_rst_proto", 32'(proto_err), 32'h0);
      bus.mem_rvalid = 1'b1;
      step();
      bus.mem_rvalid = 1'b0;
      chk("post_rst_stray_proto", 32'(proto_err), 32'h1);
      chk("post_rst_no_valid", 32'(bus.wb_valid), 32'h0);

      do_reset();
      step();
      pend.delete();
      results.delete();
      run_model(25, 1'b1);
      run_model(400, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
